// File: rtl/log_ram_dump_reader.sv
// Log RAM dump reader: when the log BRAM reports full and a dump is requested, reads every
// address in order through the BRAM read port and streams each word out on a valid/ready
// interface. Each word costs FETCH (rd_en), WAIT (BRAM latency) and at least one HOLD cycle.
module log_ram_dump_reader #(
    parameter int unsigned NB_LOG_DATA = 16,
    parameter int unsigned NB_ADDR     = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_log_ram_full,
    output logic                   o_ram_rd_en,
    output logic [NB_ADDR-1:0]     o_ram_rd_addr,
    input  logic [NB_LOG_DATA-1:0] i_ram_rd_data,
    output logic [NB_LOG_DATA-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StHold,
        StDone
    } state_e;

    localparam logic [NB_ADDR-1:0] LastAddr = '1;
    localparam logic [NB_ADDR-1:0] AddrOne  = {{(NB_ADDR-1){1'b0}}, 1'b1};

    state_e state_q;

    // Dump sequencer; every output is a register, and o_ram_rd_addr doubles as the address counter.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q       <= StIdle;
            o_ram_rd_en   <= 1'b0;
            o_ram_rd_addr <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else if (state_q != StIdle && i_abort) begin
            // Abort beats a simultaneous transfer: the word on the bus is dropped.
            state_q     <= StIdle;
            o_ram_rd_en <= 1'b0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start && i_log_ram_full) begin
                        state_q       <= StFetch;
                        o_ram_rd_addr <= '0;
                        o_ram_rd_en   <= 1'b1;
                        o_busy        <= 1'b1;
                    end
                end
                StFetch: begin
                    o_ram_rd_en <= 1'b0;
                    state_q     <= StWait;
                end
                StWait: begin
                    o_data  <= i_ram_rd_data;
                    o_valid <= 1'b1;
                    state_q <= StHold;
                end
                StHold: begin
                    if (o_valid && i_ready) begin
                        o_valid <= 1'b0;
                        if (o_ram_rd_addr == LastAddr) begin
                            o_done  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            o_ram_rd_addr <= o_ram_rd_addr + AddrOne;
                            o_ram_rd_en   <= 1'b1;
                            state_q       <= StFetch;
                        end
                    end
                end
                StDone: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
